// File: rtl/sigmoid_a1_grad_pkg.sv
// Shared constants for the sigmoid backward-pass gradient gate.
package sigmoid_a1_grad_pkg;

  // Half-precision word width
  localparam int HALF_W = 16;

  // Half-precision zero, loaded when the gradient is gated off
  localparam logic [HALF_W-1:0] HALF_ZERO = 16'h0000;

  // Exponent MSB of a half: set means |x| >= 2, the region where the
  // piecewise sigmoid is flat and its derivative is treated as zero
  localparam int SAT_BIT = 14;

endpackage

// File: rtl/sigmoid_mask_fifo.sv
// One-bit-wide mask FIFO. It records, in forward order, whether each
// forward sample fell in the saturated region. The occupancy count is the
// only full/empty indicator, so the pointers simply wrap modulo DEPTH.
module sigmoid_mask_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard both ports locally so a full push or empty pop cannot corrupt state
  always_comb begin
    do_push = push && (count != CNT_W'(DEPTH));
    do_pop  = pop  && (count != '0);
    dout    = mem[rd_ptr];
  end

  // Pointer/count update; rst and flush both override any same-cycle traffic
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sigmoid_a1_grad.sv
// Backward-pass gate for a piecewise-linear sigmoid. Forward samples push a
// saturation mask bit; each upstream gradient pops the oldest bit and is
// either passed through (linear region) or zeroed (saturated region).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. fwd_ready and grad_in_ready do not depend on their own valid;
// grad_out is held stable while grad_out_valid is high and grad_out_ready low.
module sigmoid_a1_grad
  import sigmoid_a1_grad_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   fwd_valid,
  input  logic [15:0]            fwd_in,
  output logic                   fwd_ready,
  input  logic                   grad_in_valid,
  input  logic [15:0]            grad_in,
  output logic                   grad_in_ready,
  output logic                   grad_out_valid,
  output logic [15:0]            grad_out,
  input  logic                   grad_out_ready,
  output logic [$clog2(DEPTH):0] mask_count,
  output logic [15:0]            sat_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic push;
  logic accept;
  logic mask_bit;

  // Handshake decode; the output register frees up when empty or being drained
  always_comb begin
    fwd_ready     = (mask_count != CNT_W'(DEPTH));
    grad_in_ready = (mask_count != '0) && (!grad_out_valid || grad_out_ready);
    push          = fwd_valid && fwd_ready;
    accept        = grad_in_valid && grad_in_ready;
  end

  sigmoid_mask_fifo #(
    .DEPTH (DEPTH)
  ) u_mask_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (fwd_in[SAT_BIT]),
    .pop   (accept),
    .dout  (mask_bit),
    .count (mask_count)
  );

  // Output register and saturated-gradient counter
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      grad_out_valid <= 1'b0;
      grad_out       <= HALF_ZERO;
      sat_count      <= '0;
    end else begin
      if (accept) begin
        grad_out_valid <= 1'b1;
        grad_out       <= mask_bit ? HALF_ZERO : grad_in;
        if (mask_bit && (sat_count != 16'hFFFF)) begin
          sat_count <= sat_count + 16'd1;
        end
      end else if (grad_out_ready) begin
        grad_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_a1_grad.sv
// Self-checking bench for sigmoid_a1_grad: directed scenarios plus random
// traffic, checked against a queue-based model of the mask FIFO and output.
module tb_sigmoid_a1_grad;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             fwd_valid;
  logic [15:0]      fwd_in;
  logic             fwd_ready;
  logic             grad_in_valid;
  logic [15:0]      grad_in;
  logic             grad_in_ready;
  logic             grad_out_valid;
  logic [15:0]      grad_out;
  logic             grad_out_ready;
  logic [CNT_W-1:0] mask_count;
  logic [15:0]      sat_count;

  sigmoid_a1_grad #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_in         (fwd_in),
    .fwd_ready      (fwd_ready),
    .grad_in_valid  (grad_in_valid),
    .grad_in        (grad_in),
    .grad_in_ready  (grad_in_ready),
    .grad_out_valid (grad_out_valid),
    .grad_out       (grad_out),
    .grad_out_ready (grad_out_ready),
    .mask_count     (mask_count),
    .sat_count      (sat_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          mq[$];          // stored mask bits, oldest first
  bit          mdl_ov;         // model grad_out_valid
  int          mdl_sat;        // model sat_count (unbounded, clipped on compare)
  logic [15:0] exp_q[$];       // expected grad_out words, oldest first

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] sat_clip(input int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  // ---------------- monitor ----------------
  // Output held while valid: compare against head; retire on handshake.
  always @(negedge clk) begin
    if (grad_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none at %0t", grad_out, $time);
      end else begin
        check("grad_out", {16'h0, grad_out}, {16'h0, exp_q[0]});
        if (grad_out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, compare status at the negedge, then
  // advance the model at the rising edge using the model's own handshakes.
  task automatic step(input bit fv, input logic [15:0] fin, input bit gv,
                      input logic [15:0] gin, input bit gr, input bit fl, input bit rs);
    bit m_push, m_acc, m;
    fwd_valid      = fv;
    fwd_in         = fin;
    grad_in_valid  = gv;
    grad_in        = gin;
    grad_out_ready = gr;
    flush          = fl;
    rst            = rs;
    @(negedge clk);
    check("mask_count",     {{(32-CNT_W){1'b0}}, mask_count}, mq.size());
    check("fwd_ready",      {31'h0, fwd_ready}, {31'h0, mq.size() != DEPTH});
    check("grad_in_ready",  {31'h0, grad_in_ready},
          {31'h0, (mq.size() != 0) && (!mdl_ov || gr)});
    check("grad_out_valid", {31'h0, grad_out_valid}, {31'h0, mdl_ov});
    check("sat_count",      {16'h0, sat_count}, {16'h0, sat_clip(mdl_sat)});
    m_push = fv && (mq.size() != DEPTH);
    m_acc  = gv && (mq.size() != 0) && (!mdl_ov || gr);
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
      exp_q.delete();
      mdl_ov  = 1'b0;
      mdl_sat = 0;
    end else begin
      if (m_acc) begin
        m = mq.pop_front();
        exp_q.push_back(m ? 16'h0000 : gin);
        mdl_ov = 1'b1;
        if (m) mdl_sat++;
      end else if (gr) begin
        mdl_ov = 1'b0;
      end
      if (m_push) mq.push_back(fin[14]);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 16'h0, 1, 0, 0);
  endtask

  task automatic do_push(input logic [15:0] v);
    step(1, v, 0, 16'h0, 1, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 4 && (mq.size() != 0 || mdl_ov); i++)
      step(0, 16'h0, 1, 16'($urandom), 1, 0, 0);
  endtask

  function automatic logic [15:0] rand_half();
    return 16'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    mdl_ov = 1'b0;
    mdl_sat = 0;
    rst = 1'b1; flush = 1'b0; fwd_valid = 1'b0; fwd_in = '0;
    grad_in_valid = 1'b0; grad_in = '0; grad_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    step(0, 16'h0, 0, 16'h0, 1, 0, 1);
    // Reset state
    check("rst_grad_out", {16'h0, grad_out}, 32'h0);
    idle(1);

    // Linear, saturated positive, saturated negative
    do_push(16'h3800);
    do_push(16'h4200);
    do_push(16'hC400);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 16'h3C00, 1, 0, 0);
    idle(2);
    check("sat_after_three", {16'h0, sat_count}, 32'd2);

    // Fill to DEPTH, push while full, then pop with a same-cycle push
    for (int i = 0; i < DEPTH; i++) do_push(rand_half());
    check("full_count", {{(32-CNT_W){1'b0}}, mask_count}, DEPTH);
    do_push(16'h4000);
    step(1, 16'h0000, 1, 16'h1234, 1, 0, 0);
    step(1, 16'h4000, 1, 16'h2345, 1, 0, 0);
    drain();
    idle(1);

    // Gradient with empty FIFO stalls
    for (int i = 0; i < 5; i++) step(0, 16'h0, 1, 16'h5555, 1, 0, 0);

    // Backpressure holds the output word
    do_push(16'h0100);
    do_push(16'h3000);
    step(0, 16'h0, 1, 16'hB800, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 16'h1111, 0, 0, 0);
    check("held_out", {16'h0, grad_out}, 32'hB800);
    drain();

    // Pointer wrap: 20 pushes interleaved with pops
    for (int i = 0; i < 20; i++)
      step(1, rand_half(), (i % 3) != 0, rand_half(), 1, 0, 0);
    drain();

    // Flush with stored masks and a valid output, then the same with rst
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) do_push(16'h4400);
      step(0, 16'h0, 1, 16'h7777, 0, 0, 0);
      step(1, 16'h4400, 1, 16'h7777, 1, k == 0, k == 1);
      check("post_clear_count", {{(32-CNT_W){1'b0}}, mask_count}, 0);
      check("post_clear_valid", {31'h0, grad_out_valid}, 0);
      check("post_clear_sat",   {16'h0, sat_count}, 0);
      idle(1);
    end

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 60, rand_half(), $urandom_range(0, 99) < 55,
           rand_half(), $urandom_range(0, 99) < 70,
           $urandom_range(0, 199) == 0, 1'b0);
    drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
